flit_packetizer: RTL and testbench
==================================

FLIT_PACKETIZER -- requirements
Module: flit_packetizer

Interface
REQ-001 Parameter FLIT_WIDTH, default 32, flit width; payload width PW = FLIT_WIDTH-2.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 msg_valid  in  1  host offers a message descriptor.
REQ-006 msg_dst  in  8  destination node id.
REQ-007 msg_src  in  8  source node id.
REQ-008 msg_len  in  4  payload word count, 0..15.
REQ-009 msg_ready  out  1  descriptor accepted when msg_valid && msg_ready.
REQ-010 payload_in  in  PW  host payload word.
REQ-011 payload_valid  in  1  payload_in valid.
REQ-012 payload_ready  out  1  payload word consumed when payload_valid && payload_ready.
REQ-013 nic_we  in  1  downstream network interface can accept a flit this cycle.
REQ-014 flit_out  out  FLIT_WIDTH  flit to the network interface flit_in.
REQ-015 in_trigger  out  1  flit_out is written downstream this cycle.
REQ-016 seq_id  out  8  sequence number of the next packet.

Function
REQ-017 Flit bits [FW-1:FW-2] SHALL hold the type: 00 HEAD, 01 BODY, 10 TAIL, 11 HEADTAIL.
REQ-018 Header flit: type, dst [FW-3:FW-10], src [FW-11:FW-18], len [FW-19:FW-22], seq_id [FW-23:FW-30], remaining bits zero.
REQ-019 Body/tail flit: type, then payload_in[PW-1:0] unmodified.
REQ-020 FSM states: IDLE, HEAD, BODY.
REQ-021 IDLE: msg_ready=1, in_trigger=0, payload_ready=0; on msg_valid, latch dst/src/len and go to HEAD next cycle.
REQ-022 HEAD: flit_out=header from latched fields, in_trigger=nic_we; type HEADTAIL if len==0, else HEAD.
REQ-023 HEAD with nic_we: len==0 -> IDLE and seq_id+1; else load remaining counter with len and go to BODY.
REQ-024 HEAD without nic_we: hold state and flit_out stable.
REQ-025 BODY: payload_ready=nic_we, in_trigger=nic_we && payload_valid, flit_out type TAIL when remaining==1, else BODY.
REQ-026 BODY transfer (in_trigger=1): remaining decrements; if remaining was 1 -> IDLE and seq_id+1.
REQ-027 BODY with payload_valid=0 or nic_we=0: no transfer, no counter change, in_trigger=0.
REQ-028 in_trigger SHALL never assert when nic_we=0.
REQ-029 msg_ready=0 in HEAD and BODY; descriptors are not queued.
REQ-030 Latency: header flit is offered the cycle after descriptor acceptance; body flits are combinational from payload_in, zero cycle.
REQ-031 seq_id wraps 255 -> 0 without error.
REQ-032 A packet of len N produces exactly N+1 flits, back-to-back when nic_we and payload_valid stay high.
REQ-033 After a tail transfer, IDLE accepts a new descriptor the next cycle; one idle cycle between packets minimum.

Reset
REQ-034 rst SHALL force state IDLE, seq_id=0, remaining=0, latched fields=0.
REQ-035 Reset outputs: msg_ready=1, payload_ready=0, in_trigger=0, flit_out=0.
REQ-036 rst mid-packet SHALL abandon the packet with no further flits; seq_id returns to 0.

Structure
REQ-037 Shared package types SHALL hold the flit_type_t enum, the header field struct, and the packetizer state enum.
REQ-038 Field offsets SHALL be package constants derived from FLIT_WIDTH.
REQ-039 One sub-module, flit_header_encoder (combinational, fields -> header flit), is permitted; everything else stays in flit_packetizer.

Verification
REQ-040 Descriptor dst=0x12, src=0x34, len=0, nic_we=1 -> one flit 0xC48D0000, in_trigger one cycle, seq_id 0->1.
REQ-041 len=3, payloads 0x1,0x2,0x3, always valid, nic_we=1 -> HEAD, BODY 0x40000001, BODY 0x40000002, TAIL 0x80000003 on 4 consecutive cycles.
REQ-042 len=2, nic_we low 3 cycles during HEAD -> header held stable, in_trigger=0 for those cycles, then sequence completes.
REQ-043 len=4, payload_valid toggling 1/0 -> in_trigger only on valid cycles, exactly 4 body/tail flits, TAIL on the 4th.
REQ-044 Send 256 len=0 packets -> seq_id field in the 257th header is 0.
REQ-045 rst asserted after the 2nd body flit of len=5 -> next cycle IDLE, in_trigger=0, seq_id=0, msg_ready=1.

Source files
------------

// File: rtl/flit_packetizer_pkg.sv
// Shared types and header field placement for the flit packetizer.
// Field positions are expressed as offsets below the flit MSB so any FLIT_WIDTH >= 30 works.
package flit_packetizer_pkg;

    localparam int DEFAULT_FLIT_WIDTH = 32;

    localparam int TYPE_W = 2;
    localparam int NODE_W = 8;
    localparam int LEN_W  = 4;
    localparam int SEQ_W  = 8;

    // Offset of each field's MSB below the flit MSB.
    localparam int TYPE_OFS = 0;
    localparam int DST_OFS  = TYPE_OFS + TYPE_W;
    localparam int SRC_OFS  = DST_OFS + NODE_W;
    localparam int LEN_OFS  = SRC_OFS + NODE_W;
    localparam int SEQ_OFS  = LEN_OFS + LEN_W;
    localparam int HDR_BITS = SEQ_OFS + SEQ_W;

    typedef enum logic [1:0] {
        FLIT_HEAD     = 2'b00,
        FLIT_BODY     = 2'b01,
        FLIT_TAIL     = 2'b10,
        FLIT_HEADTAIL = 2'b11
    } flit_type_t;

    typedef struct packed {
        logic [NODE_W-1:0] dst;
        logic [NODE_W-1:0] src;
        logic [LEN_W-1:0]  len;
        logic [SEQ_W-1:0]  seq;
    } hdr_fields_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } pkt_state_t;

    function automatic int field_msb(input int flit_width, input int ofs);
        return flit_width - 1 - ofs;
    endfunction

endpackage

// File: rtl/flit_packetizer_if.sv
// Host/network-side signal bundle of the flit packetizer.
// Handshakes: a word moves on a rising clk edge where valid && ready (msg_*, payload_*);
// the producer holds data stable while valid is high, and a flit leaves when in_trigger is high.
interface flit_packetizer_if #(
    parameter int FLIT_WIDTH = 32
);
    localparam int PW = FLIT_WIDTH - 2;

    logic                  msg_valid;
    logic [7:0]            msg_dst;
    logic [7:0]            msg_src;
    logic [3:0]            msg_len;
    logic                  msg_ready;
    logic [PW-1:0]         payload_in;
    logic                  payload_valid;
    logic                  payload_ready;
    logic                  nic_we;
    logic [FLIT_WIDTH-1:0] flit_out;
    logic                  in_trigger;
    logic [7:0]            seq_id;

    modport master (
        output msg_valid, msg_dst, msg_src, msg_len,
        output payload_in, payload_valid, nic_we,
        input  msg_ready, payload_ready, flit_out, in_trigger, seq_id
    );

    modport slave (
        input  msg_valid, msg_dst, msg_src, msg_len,
        input  payload_in, payload_valid, nic_we,
        output msg_ready, payload_ready, flit_out, in_trigger, seq_id
    );

endinterface

// File: rtl/flit_packetizer_header_encoder.sv
// Combinational packing of header fields and flit type into a header flit.
// Bits below the sequence field are driven to zero.
module flit_header_encoder
    import flit_packetizer_pkg::*;
#(
    parameter int FLIT_WIDTH = DEFAULT_FLIT_WIDTH
) (
    input  hdr_fields_t           fields,
    input  flit_type_t            ftype,
    output logic [FLIT_WIDTH-1:0] flit
);
    localparam int TYPE_MSB = field_msb(FLIT_WIDTH, TYPE_OFS);
    localparam int DST_MSB  = field_msb(FLIT_WIDTH, DST_OFS);
    localparam int SRC_MSB  = field_msb(FLIT_WIDTH, SRC_OFS);
    localparam int LEN_MSB  = field_msb(FLIT_WIDTH, LEN_OFS);
    localparam int SEQ_MSB  = field_msb(FLIT_WIDTH, SEQ_OFS);

    always_comb begin
        flit                     = '0;
        flit[TYPE_MSB -: TYPE_W] = ftype;
        flit[DST_MSB  -: NODE_W] = fields.dst;
        flit[SRC_MSB  -: NODE_W] = fields.src;
        flit[LEN_MSB  -: LEN_W]  = fields.len;
        flit[SEQ_MSB  -: SEQ_W]  = fields.seq;
    end

endmodule

// File: rtl/flit_packetizer.sv
// Turns a message descriptor plus payload words into HEAD/BODY/TAIL flits for a NIC.
// Body flits pass payload_in straight through in the cycle it is consumed.
module flit_packetizer
    import flit_packetizer_pkg::*;
#(
    parameter int FLIT_WIDTH = DEFAULT_FLIT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    flit_packetizer_if.slave      bus,
    output pkt_state_t            dbg_state
);
    localparam int PW = FLIT_WIDTH - 2;

    pkt_state_t            state;
    logic [NODE_W-1:0]     dst_q;
    logic [NODE_W-1:0]     src_q;
    logic [LEN_W-1:0]      len_q;
    logic [SEQ_W-1:0]      seq_q;
    logic [LEN_W-1:0]      remaining;

    hdr_fields_t           hdr;
    flit_type_t            hdr_type;
    flit_type_t            body_type;
    logic [FLIT_WIDTH-1:0] hdr_flit;
    logic                  head_xfer;
    logic                  body_xfer;

    assign hdr       = '{dst: dst_q, src: src_q, len: len_q, seq: seq_q};
    assign hdr_type  = (len_q == '0) ? FLIT_HEADTAIL : FLIT_HEAD;
    assign body_type = (remaining == 4'd1) ? FLIT_TAIL : FLIT_BODY;
    assign head_xfer = (state == ST_HEAD) && bus.nic_we;
    assign body_xfer = (state == ST_BODY) && bus.nic_we && bus.payload_valid;

    flit_header_encoder #(
        .FLIT_WIDTH(FLIT_WIDTH)
    ) u_hdr_enc (
        .fields(hdr),
        .ftype (hdr_type),
        .flit  (hdr_flit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            dst_q     <= '0;
            src_q     <= '0;
            len_q     <= '0;
            seq_q     <= '0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.msg_valid) begin
                        dst_q <= bus.msg_dst;
                        src_q <= bus.msg_src;
                        len_q <= bus.msg_len;
                        state <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (head_xfer) begin
                        if (len_q == '0) begin
                            seq_q <= seq_q + 8'd1;
                            state <= ST_IDLE;
                        end else begin
                            remaining <= len_q;
                            state     <= ST_BODY;
                        end
                    end
                end
                ST_BODY: begin
                    if (body_xfer) begin
                        remaining <= remaining - 4'd1;
                        if (remaining == 4'd1) begin
                            seq_q <= seq_q + 8'd1;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are forced to their idle values while rst is high so an abandoned
    // packet cannot emit a flit in the reset cycle itself.
    assign bus.msg_ready     = rst || (state == ST_IDLE);
    assign bus.payload_ready = !rst && (state == ST_BODY) && bus.nic_we;
    assign bus.in_trigger    = !rst && (head_xfer || body_xfer);
    assign bus.seq_id        = seq_q;
    assign dbg_state         = state;

    always_comb begin
        bus.flit_out = '0;
        if (!rst) begin
            case (state)
                ST_HEAD: bus.flit_out = hdr_flit;
                ST_BODY: bus.flit_out = {body_type, bus.payload_in[PW-1:0]};
                default: bus.flit_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_flit_packetizer.sv
// Randomized bench for flit_packetizer with a packet-level reference model.
// Inputs change 1 ns after posedge; outputs are sampled on negedge.
module tb_flit_packetizer;
    import flit_packetizer_pkg::*;

    localparam int FW = 32;

    typedef struct {
        logic [7:0] dst;
        logic [7:0] src;
        logic [3:0] len;
    } desc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flit_packetizer_if #(.FLIT_WIDTH(FW)) bus ();
    pkt_state_t dbg_state;

    flit_packetizer #(.FLIT_WIDTH(FW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] obs_log[$];
    logic [29:0]   pay_q[$];
    desc_t         desc_q[$];
    desc_t         cur;
    logic [7:0]    seq_model = 8'd0;
    bit            hdr_pending = 0;
    bit            accepted = 0;
    bit            tog = 0;
    int            cyc = 0;
    int            accept_cyc = 0;
    int            last_cyc = 0;

    int nic_pct = 100;
    int val_pct = 100;
    bit val_toggle = 0;
    bit counting = 0;
    int hold_cycles = 0;
    int nic_low_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] hdr_word(input desc_t d, input logic [7:0] seq);
        logic [31:0] t;
        t = (d.len == 4'd0) ? 32'd3 : 32'd0;
        return (t << 30) + (32'(d.dst) << 22) + (32'(d.src) << 14)
             + (32'(d.len) << 10) + (32'(seq) << 2);
    endfunction

    function automatic logic [31:0] body_word(input int k, input int len, input logic [29:0] p);
        logic [31:0] t;
        t = (k == len) ? 32'd2 : 32'd1;
        return (t << 30) + 32'(p);
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            check("rst_trig", 32'(bus.in_trigger), 32'd0);
            check("rst_msg_ready", 32'(bus.msg_ready), 32'd1);
            exp_q.delete();
            pay_q.delete();
            hdr_pending = 0;
            accepted    = 0;
            seq_model   = 8'd0;
        end else begin
            if (!bus.nic_we) check("trig_no_we", 32'(bus.in_trigger), 32'd0);
            check("msg_ready", 32'(bus.msg_ready), 32'(exp_q.size() == 0));
            check("payload_ready", 32'(bus.payload_ready),
                  32'(exp_q.size() != 0 && !hdr_pending && bus.nic_we));
            if (hdr_pending) check("hdr_flit", bus.flit_out, exp_q[0]);
            if (bus.in_trigger) begin
                obs_log.push_back(bus.flit_out);
                if (!hdr_pending) check("trig_no_valid", 32'(bus.payload_valid), 32'd1);
                if (exp_q.size() == 0) begin
                    check("extra_flit", 32'(bus.in_trigger), 32'd0);
                end else begin
                    check("flit", bus.flit_out, exp_q.pop_front());
                    last_cyc = cyc;
                end
                hdr_pending = 0;
            end
            if (bus.payload_valid && bus.payload_ready && pay_q.size() > 0)
                void'(pay_q.pop_front());
            if (bus.msg_valid && bus.msg_ready) begin
                accepted    = 1;
                hdr_pending = 1;
                accept_cyc  = cyc;
                exp_q.push_back(hdr_word(cur, seq_model));
                for (int k = 1; k <= int'(cur.len); k++) begin
                    logic [29:0] p;
                    p = counting ? 30'(k) : 30'($urandom);
                    pay_q.push_back(p);
                    exp_q.push_back(body_word(k, int'(cur.len), p));
                end
                seq_model = seq_model + 8'd1;
            end
        end
    end

    // Driver
    always @(posedge clk) begin
        #1;
        if (rst) begin
            bus.msg_valid     = 1'b0;
            bus.nic_we        = 1'b0;
            bus.payload_valid = 1'b0;
            nic_low_cnt       = 0;
        end else begin
            if (accepted) begin
                bus.msg_valid = 1'b0;
                accepted      = 0;
                nic_low_cnt   = hold_cycles;
            end
            if (!bus.msg_valid && desc_q.size() > 0 && exp_q.size() == 0) begin
                cur           = desc_q.pop_front();
                bus.msg_dst   = cur.dst;
                bus.msg_src   = cur.src;
                bus.msg_len   = cur.len;
                bus.msg_valid = 1'b1;
            end
            if (nic_low_cnt > 0) begin
                bus.nic_we  = 1'b0;
                nic_low_cnt = nic_low_cnt - 1;
            end else begin
                bus.nic_we = (int'($urandom_range(99)) < nic_pct);
            end
            tog = ~tog;
            if (pay_q.size() > 0 && (val_toggle ? tog : (int'($urandom_range(99)) < val_pct))) begin
                bus.payload_valid = 1'b1;
                bus.payload_in    = pay_q[0];
            end else begin
                bus.payload_valid = 1'b0;
                bus.payload_in    = 30'($urandom);
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while ((desc_q.size() != 0 || bus.msg_valid || exp_q.size() != 0) && n < budget);
        check("done", 32'(n < budget), 32'd1);
    endtask

    task automatic run_packet(input logic [7:0] dst, input logic [7:0] src, input logic [3:0] len,
                              input int npct, input int vpct, input bit tgl, input int hold,
                              input bit cnt);
        desc_t d;
        nic_pct     = npct;
        val_pct     = vpct;
        val_toggle  = tgl;
        hold_cycles = hold;
        counting    = cnt;
        d.dst = dst;
        d.src = src;
        d.len = len;
        obs_log.delete();
        desc_q.push_back(d);
        wait_idle(400);
        check("seq_id", 32'(bus.seq_id), 32'(seq_model));
        if (npct == 100 && vpct == 100 && !tgl && hold == 0)
            check("latency", 32'(last_cyc - accept_cyc), 32'(int'(len) + 1));
    endtask

    initial begin
        logic [31:0] w;
        int n;
        bus.msg_valid     = 1'b0;
        bus.msg_dst       = '0;
        bus.msg_src       = '0;
        bus.msg_len       = '0;
        bus.payload_valid = 1'b0;
        bus.payload_in    = '0;
        bus.nic_we        = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #2;
        check("reset_msg_ready", 32'(bus.msg_ready), 32'd1);
        check("reset_payload_ready", 32'(bus.payload_ready), 32'd0);
        check("reset_trigger", 32'(bus.in_trigger), 32'd0);
        check("reset_flit", bus.flit_out, 32'd0);
        check("reset_seq", 32'(bus.seq_id), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));

        // Single HEADTAIL flit
        run_packet(8'h12, 8'h34, 4'd0, 100, 100, 0, 0, 1);
        check("ht_count", 32'(obs_log.size()), 32'd1);
        w = obs_log[0];
        check("ht_flit", w, 32'hC48D0000);
        check("ht_seq", 32'(bus.seq_id), 32'd1);

        // Back-to-back len=3
        run_packet(8'h12, 8'h34, 4'd3, 100, 100, 0, 0, 1);
        check("b2b_count", 32'(obs_log.size()), 32'd4);
        w = obs_log[0]; check("b2b_head", w, 32'h048D0C04);
        w = obs_log[1]; check("b2b_body1", w, 32'h40000001);
        w = obs_log[2]; check("b2b_body2", w, 32'h40000002);
        w = obs_log[3]; check("b2b_tail", w, 32'h80000003);

        // NIC stalls the header for 3 cycles
        run_packet(8'hA5, 8'h5A, 4'd2, 100, 100, 0, 3, 0);
        check("hold_latency", 32'(last_cyc - accept_cyc), 32'd6);
        check("hold_count", 32'(obs_log.size()), 32'd3);

        // Payload valid toggling
        run_packet(8'h01, 8'h02, 4'd4, 100, 100, 1, 0, 0);
        check("tgl_count", 32'(obs_log.size()), 32'd5);
        w = obs_log[4];
        check("tgl_tail_type", 32'(w[31:30]), 32'd2);

        // Random traffic
        for (int i = 0; i < 40; i++)
            run_packet(8'($urandom), 8'($urandom), 4'($urandom_range(15)),
                       int'($urandom_range(100, 40)), int'($urandom_range(100, 30)),
                       1'b0, int'($urandom_range(2)), 1'b0);

        // Reset after the second body flit of a len=5 packet
        nic_pct = 100; val_pct = 100; val_toggle = 0; hold_cycles = 0; counting = 0;
        obs_log.delete();
        desc_q.push_back('{dst: 8'h77, src: 8'h88, len: 4'd5});
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (exp_q.size() != 3 && n < 100);
        check("rst_wait", 32'(n < 100), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        check("abort_trigger", 32'(bus.in_trigger), 32'd0);
        check("abort_seq", 32'(bus.seq_id), 32'd0);
        check("abort_msg_ready", 32'(bus.msg_ready), 32'd1);
        repeat (6) @(posedge clk);
        #2;
        check("abort_flits", 32'(obs_log.size()), 32'd3);

        // Sequence number wrap
        for (int i = 0; i < 256; i++)
            run_packet(8'(i), 8'(255 - i), 4'd0, 100, 100, 0, 0, 0);
        check("wrap_seq", 32'(bus.seq_id), 32'd0);
        run_packet(8'h12, 8'h34, 4'd0, 100, 100, 0, 0, 0);
        w = obs_log[0];
        check("wrap_hdr_seq", 32'(w[9:2]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
